ifft_8point_idft: RTL and testbench
===================================

IFFT_8POINT_IDFT -- requirements
Module: ifft_8point_idft

Interface
REQ-001 Parameter C_AXIS_TDATA_WIDTH, default 512: input beat width, 8 complex bins.
REQ-002 Parameter C_AXIS_TOUT_WIDTH, default 64: output beat width, 8 real Q7 samples.
REQ-003 Parameter C_AXIS_TUSER_WIDTH, default 1: output tuser width.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 Port s_axis_aclk, input, 1: the only clock; all ports are synchronous to it.
REQ-006 Port s_axis_areset, input, 1: asynchronous active-high reset.
REQ-007 Port s_axis_tvalid, input, 1: input beat valid.
REQ-008 Port s_axis_tready, output, 1: input beat accept.
REQ-009 Port s_axis_tdata, input, 512: bin k real part at [64k+63:64k+32] and imaginary part at [64k+31:64k], signed 32-bit, Q7 scale.
REQ-010 Port s_axis_tlast, input, 1: frame marker, passed through.
REQ-011 Port m_axis_tvalid, output, 1: output beat valid.
REQ-012 Port m_axis_tready, input, 1: downstream accept.
REQ-013 Port m_axis_tdata, output, 64: sample n at [8n+7:8n], signed Q7.
REQ-014 Port m_axis_tlast, output, 1: delayed s_axis_tlast.
REQ-015 Port m_axis_tuser, output, 1: high when any sample in the beat saturated.
REQ-016 Port m_axis_tkeep, output, 8: constant all-ones.
REQ-017 Port sat_clear, input, 1: synchronous clear of sat_count.
REQ-018 Port sat_count, output, 16: running count of saturated samples.

Function
REQ-019 s_axis_tready SHALL equal ~m_axis_tvalid | m_axis_tready; every pipeline register (valid, tlast, data) SHALL advance only when s_axis_tready=1.
REQ-020 Pipeline depth SHALL be 3 registers: a beat accepted on edge N SHALL be presented on m_axis_* after edge N+2 when there is no stall.
REQ-021 Stage A (register 1) SHALL compute complex a0=X0+X4, a1=X0-X4, a2=X2+X6, a3=X2-X6, b0=X1+X5, b1=X1-X5, b2=X3+X7, b3=X3-X7.
REQ-022 Stage B (register 2) SHALL compute e0=a0+a2, e2=a0-a2, e1=a1+j·a3, e3=a1-j·a3; o0=b0+b2, o2=b0-b2, o1=b1+j·b3, o3=b1-j·b3.
REQ-023 Stage C (register 3) SHALL compute real y[n]=Re(e[n]+t[n]) and y[n+4]=Re(e[n]-t[n]) for n=0..3, where t0=o0, t1 real=(o1re·23170 - o1im·23170)>>>15, t2 real=-o2im, t3 real=(-o3re·23170 - o3im·23170)>>>15.
REQ-024 >>> SHALL be an arithmetic (floor) shift applied to the full-precision sum of both products.
REQ-025 Output sample x[n] SHALL be y[n]>>>3 (floor), saturated to [-128,127].
REQ-026 Internal widths SHALL be at least 52 bits, so that no intermediate value wraps for any 32-bit input.
REQ-027 m_axis_tuser SHALL be the OR of the per-sample saturation flags of the same beat.
REQ-028 Imaginary parts of the outputs SHALL be discarded.
REQ-029 On stall (m_axis_tvalid=1, m_axis_tready=0), all stages SHALL hold and m_axis_* SHALL remain stable.
REQ-030 Bubbles (invalid beats) SHALL propagate, and a bubble in the output register SHALL be overwritten without waiting for m_axis_tready.
REQ-031 On each m_axis handshake, sat_count SHALL add the number of saturated samples in the beat, saturating at 65535.
REQ-032 When sat_clear=1, sat_count SHALL become 0 on the next edge, and the clear SHALL win over a same-cycle increment.
REQ-033 s_axis_tlast SHALL travel with its beat through all 3 stages to m_axis_tlast.

Reset
REQ-034 While s_axis_areset=1, all valid bits, m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata and sat_count SHALL be 0 immediately, without waiting for a clock edge.
REQ-035 Beats in flight at reset SHALL be discarded and never emitted.
REQ-036 s_axis_tready SHALL read 1 during reset and after reset release.

Verification
REQ-037 All bins Xk=(64,0), m_axis_tready=1 -> after 3 edges, x=[64,0,0,0,0,0,0,0], tuser=0.
REQ-038 X1=(800,0), others 0 -> x=[100,70,0,-71,-100,-71,0,70], tuser=0.
REQ-039 X0=(1024,0) then X0=(-1024,0), others 0 -> first beat all 127 with tuser=1 and sat_count=8; second beat all -128 with tuser=0 and sat_count still 8.
REQ-040 Stream 5 beats and hold m_axis_tready=0 for 6 cycles mid-stream -> s_axis_tready=0 while stalled, m_axis_tdata stable, all 5 beats out in order with no loss or duplication, tlast on beat 5 only.
REQ-041 Assert s_axis_areset asynchronously with 2 beats in flight -> m_axis_tvalid=0 and sat_count=0 before the next edge; no output after release until a new beat enters.
REQ-042 sat_clear and a saturating handshake in the same cycle -> sat_count=0 on the next cycle.

Source files
------------

// File: rtl/ifft_8point_idft.sv
// ifft_8point_idft
//   Streaming 8-point inverse DFT. Each input beat carries 8 complex Q7 bins.
//   Each output beat carries the 8 real Q7 time samples, computed as
//   x[n] = (sum_k X[k] * e^{+j*2*pi*k*n/8}) / 8, then floored and saturated.
//   The datapath is a radix-2 decimation-in-time pipeline of three registers
//   (butterflies, quarter-twiddle combine, final twiddle/saturate). All three
//   registers share one enable, so a stall freezes the whole pipe.
//
// Ports
//   s_axis_aclk    : the only clock
//   s_axis_areset  : asynchronous active-high reset
//   s_axis_t*      : input stream (tvalid/tready/tdata/tlast)
//   m_axis_t*      : output stream (tvalid/tready/tdata/tlast/tuser/tkeep)
//   sat_clear      : synchronous clear of sat_count (wins over an increment)
//   sat_count      : running count of saturated samples, sticks at 65535
module ifft_8point_idft #(
  parameter int C_AXIS_TDATA_WIDTH = 512,
  parameter int C_AXIS_TOUT_WIDTH  = 64,
  parameter int C_AXIS_TUSER_WIDTH = 1
) (
  input  logic                            s_axis_aclk,
  input  logic                            s_axis_areset,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                            s_axis_tlast,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic [C_AXIS_TOUT_WIDTH-1:0]    m_axis_tdata,
  output logic                            m_axis_tlast,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic [C_AXIS_TOUT_WIDTH/8-1:0]  m_axis_tkeep,
  input  logic                            sat_clear,
  output logic [15:0]                     sat_count
);

  // 52 bits covers 32-bit inputs grown by two adder stages plus a Q15 product.
  localparam int IW = 52;
  typedef logic signed [IW-1:0] wide_t;

  localparam wide_t COS_Q15 = wide_t'(23170);   // cos(pi/4) in Q15
  localparam wide_t Q7_MAX  = wide_t'(127);
  localparam wide_t Q7_MIN  = -wide_t'(128);

  logic adv;

  // Input bins, sign-extended
  wide_t x_re [8];
  wide_t x_im [8];

  // Stage A: a0..a3 at [0..3], b0..b3 at [4..7]
  wide_t a_re_next [8];
  wide_t a_im_next [8];
  wide_t a_re_reg  [8];
  wide_t a_im_reg  [8];
  logic  a_valid_reg, a_last_reg;

  // Stage B: e0..e3 at [0..3], o0..o3 at [4..7]
  wide_t f_re_next [8];
  wide_t f_im_next [8];
  wide_t f_re_reg  [8];
  wide_t f_im_reg  [8];
  logic  f_valid_reg, f_last_reg;

  // Stage C
  wide_t                        t_re [4];
  wide_t                        y    [8];
  logic [7:0]                   sat_flag;
  logic [C_AXIS_TOUT_WIDTH-1:0] out_data_next;
  logic [3:0]                   sat_num_next;

  logic                         out_valid_reg, out_last_reg, out_sat_any_reg;
  logic [C_AXIS_TOUT_WIDTH-1:0] out_data_reg;
  logic [3:0]                   out_sat_num_reg;
  logic [15:0]                  sat_count_reg;
  logic [16:0]                  sat_sum;

  // A bubble in the output register leaves the pipe free to move.
  assign s_axis_tready = ~out_valid_reg | m_axis_tready;
  assign adv           = s_axis_tready;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_unpack
      assign x_re[gi] = wide_t'($signed(s_axis_tdata[64*gi+32 +: 32]));
      assign x_im[gi] = wide_t'($signed(s_axis_tdata[64*gi    +: 32]));
    end

    // Pair order 0,2,1,3 puts the even-index butterflies in the lower half.
    for (gi = 0; gi < 4; gi++) begin : g_stage_a
      localparam int P = (gi % 2) * 2 + gi / 2;
      assign a_re_next[2*gi]   = x_re[P] + x_re[P+4];
      assign a_im_next[2*gi]   = x_im[P] + x_im[P+4];
      assign a_re_next[2*gi+1] = x_re[P] - x_re[P+4];
      assign a_im_next[2*gi+1] = x_im[P] - x_im[P+4];
    end

    // Half 0 turns a* into e*, half 1 turns b* into o*; +j rotates (re,im)->(-im,re).
    for (gi = 0; gi < 2; gi++) begin : g_stage_b
      localparam int K = 4 * gi;
      assign f_re_next[K]   = a_re_reg[K]   + a_re_reg[K+2];
      assign f_im_next[K]   = a_im_reg[K]   + a_im_reg[K+2];
      assign f_re_next[K+2] = a_re_reg[K]   - a_re_reg[K+2];
      assign f_im_next[K+2] = a_im_reg[K]   - a_im_reg[K+2];
      assign f_re_next[K+1] = a_re_reg[K+1] - a_im_reg[K+3];
      assign f_im_next[K+1] = a_im_reg[K+1] + a_re_reg[K+3];
      assign f_re_next[K+3] = a_re_reg[K+1] + a_im_reg[K+3];
      assign f_im_next[K+3] = a_im_reg[K+1] - a_re_reg[K+3];
    end
  endgenerate

  // Only the real part of the final twiddle product is ever needed.
  always_comb begin
    t_re[0] = f_re_reg[4];
    t_re[1] = (f_re_reg[5] * COS_Q15 - f_im_reg[5] * COS_Q15) >>> 15;
    t_re[2] = -f_im_reg[6];
    t_re[3] = (-f_re_reg[7] * COS_Q15 - f_im_reg[7] * COS_Q15) >>> 15;
    for (int n = 0; n < 4; n++) begin
      y[n]   = f_re_reg[n] + t_re[n];
      y[n+4] = f_re_reg[n] - t_re[n];
    end
  end

  generate
    for (gi = 0; gi < 8; gi++) begin : g_sat
      wide_t q;
      assign q = y[gi] >>> 3;
      assign sat_flag[gi] = (q > Q7_MAX) || (q < Q7_MIN);
      assign out_data_next[8*gi +: 8] = (q > Q7_MAX) ? 8'h7f :
                                        (q < Q7_MIN) ? 8'h80 : q[7:0];
    end
  endgenerate

  assign sat_num_next = 4'($countones(sat_flag));

  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      a_valid_reg     <= 1'b0;
      a_last_reg      <= 1'b0;
      f_valid_reg     <= 1'b0;
      f_last_reg      <= 1'b0;
      out_valid_reg   <= 1'b0;
      out_last_reg    <= 1'b0;
      out_sat_any_reg <= 1'b0;
      out_sat_num_reg <= '0;
      out_data_reg    <= '0;
      for (int i = 0; i < 8; i++) begin
        a_re_reg[i] <= '0;
        a_im_reg[i] <= '0;
        f_re_reg[i] <= '0;
        f_im_reg[i] <= '0;
      end
    end else if (adv) begin
      a_valid_reg     <= s_axis_tvalid;
      a_last_reg      <= s_axis_tlast;
      f_valid_reg     <= a_valid_reg;
      f_last_reg      <= a_last_reg;
      out_valid_reg   <= f_valid_reg;
      out_last_reg    <= f_last_reg;
      out_sat_any_reg <= |sat_flag;
      out_sat_num_reg <= sat_num_next;
      out_data_reg    <= out_data_next;
      for (int i = 0; i < 8; i++) begin
        a_re_reg[i] <= a_re_next[i];
        a_im_reg[i] <= a_im_next[i];
        f_re_reg[i] <= f_re_next[i];
        f_im_reg[i] <= f_im_next[i];
      end
    end
  end

  // Saturation counter: clear has priority, increment sticks at all-ones.
  assign sat_sum = {1'b0, sat_count_reg} + 17'(out_sat_num_reg);

  always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
    if (s_axis_areset) begin
      sat_count_reg <= '0;
    end else if (sat_clear) begin
      sat_count_reg <= '0;
    end else if (out_valid_reg && m_axis_tready) begin
      sat_count_reg <= sat_sum[16] ? 16'hffff : sat_sum[15:0];
    end
  end

  assign m_axis_tvalid = out_valid_reg;
  assign m_axis_tdata  = out_data_reg;
  assign m_axis_tlast  = out_last_reg;
  assign m_axis_tuser  = C_AXIS_TUSER_WIDTH'(out_sat_any_reg);
  assign m_axis_tkeep  = '1;
  assign sat_count     = sat_count_reg;

endmodule

// File: tb/tb_ifft_8point_idft.sv
// tb_ifft_8point_idft
//   Directed-vector bench for ifft_8point_idft. Expected output beats were
//   worked out by hand from the inverse-DFT definition with floor/saturate.
module tb_ifft_8point_idft;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [511:0] s_data = '0;
  logic         s_last = 1'b0;
  logic         m_valid;
  logic         m_ready = 1'b1;
  logic [63:0]  m_data;
  logic         m_last;
  logic [0:0]   m_user;
  logic [7:0]   m_keep;
  logic         sat_clear = 1'b0;
  logic [15:0]  sat_count;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  ifft_8point_idft dut (
    .s_axis_aclk   (clk),
    .s_axis_areset (rst),
    .s_axis_tvalid (s_valid),
    .s_axis_tready (s_ready),
    .s_axis_tdata  (s_data),
    .s_axis_tlast  (s_last),
    .m_axis_tvalid (m_valid),
    .m_axis_tready (m_ready),
    .m_axis_tdata  (m_data),
    .m_axis_tlast  (m_last),
    .m_axis_tuser  (m_user),
    .m_axis_tkeep  (m_keep),
    .sat_clear     (sat_clear),
    .sat_count     (sat_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] bin(input int k, input int re, input int im);
    logic [511:0] v;
    v = '0;
    v[64*k+32 +: 32] = re;
    v[64*k    +: 32] = im;
    return v;
  endfunction

  // One beat through an otherwise idle pipe: latency, data, flags, then handshake.
  task automatic send_beat(input string tag, input logic [511:0] data, input logic last,
                           input logic [63:0] exp, input logic exp_user, input logic clr);
    s_data  = data;
    s_last  = last;
    s_valid = 1'b1;
    step();
    s_valid = 1'b0;
    s_last  = 1'b0;
    step();
    check({tag, "_early"}, m_valid, 1'b0);
    step();
    check({tag, "_valid"}, m_valid, 1'b1);
    check({tag, "_data"},  m_data,  exp);
    check({tag, "_user"},  m_user,  exp_user);
    check({tag, "_last"},  m_last,  last);
    $display("beat %s: data=%h user=%0d", tag, m_data, m_user);
    sat_clear = clr;
    step();
    sat_clear = 1'b0;
  endtask

  initial begin
    logic [511:0] all64;
    logic [63:0]  held;
    logic         stall_prev;
    logic         seen;
    int           sent, rcvd;

    all64 = '0;
    for (int k = 0; k < 8; k++) all64 |= bin(k, 64, 0);

    // Reset takes effect without a clock edge
    #1 rst = 1'b1;
    #1;
    check("rst_valid", m_valid, 1'b0);
    check("rst_data",  m_data,  64'h0);
    check("rst_count", sat_count, 16'h0);
    check("rst_ready", s_ready, 1'b1);
    check("tkeep",     m_keep,  8'hff);
    step();
    step();
    rst = 1'b0;
    step();
    check("post_rst_ready", s_ready, 1'b1);

    // Impulse-like and single-bin vectors
    send_beat("dc64",  all64,              1'b0, 64'h0000000000000040, 1'b0, 1'b0);
    send_beat("x1re",  bin(1, 800, 0),     1'b1, 64'h4600B99CB9004664, 1'b0, 1'b0);
    send_beat("x2im",  bin(2, 0, 800),     1'b0, 64'h64009C0064009C00, 1'b0, 1'b0);
    send_beat("x3im",  bin(3, 0, 800),     1'b0, 64'h469C4600B964B900, 1'b0, 1'b0);
    check("cnt_zero", sat_count, 16'd0);

    // Saturation on both rails; -1024 lands exactly on -128 without saturating
    send_beat("satp",  bin(0, 1024, 0),    1'b0, 64'h7F7F7F7F7F7F7F7F, 1'b1, 1'b0);
    check("cnt_8a", sat_count, 16'd8);
    send_beat("edgen", bin(0, -1024, 0),   1'b0, 64'h8080808080808080, 1'b0, 1'b0);
    check("cnt_8b", sat_count, 16'd8);
    send_beat("satn",  bin(0, -1040, 0),   1'b0, 64'h8080808080808080, 1'b1, 1'b0);
    check("cnt_16", sat_count, 16'd16);

    // Asynchronous reset with two beats in flight
    s_data  = bin(0, 1024, 0);
    s_valid = 1'b1;
    step();
    step();
    s_valid = 1'b0;
    step();
    check("inflight_valid", m_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", m_valid,   1'b0);
    check("arst_count", sat_count, 16'd0);
    check("arst_data",  m_data,    64'h0);
    check("arst_user",  m_user,    1'b0);
    check("arst_ready", s_ready,   1'b1);
    step();
    step();
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (m_valid) seen = 1'b1;
    end
    check("arst_no_out", seen, 1'b0);
    check("arst_cnt_hold", sat_count, 16'd0);
    send_beat("after_rst", all64, 1'b0, 64'h0000000000000040, 1'b0, 1'b0);

    // Clear coinciding with a saturating handshake
    send_beat("clr", bin(0, 1024, 0), 1'b0, 64'h7F7F7F7F7F7F7F7F, 1'b1, 1'b1);
    check("clr_wins", sat_count, 16'd0);

    // Counter sticks at 65535 (8200 beats x 8 saturated samples)
    s_data  = bin(0, 1024, 0);
    s_valid = 1'b1;
    for (int i = 0; i < 8200; i++) step();
    s_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    check("cnt_max", sat_count, 16'hffff);
    $display("stream: sat_count=%0d", sat_count);
    sat_clear = 1'b1;
    step();
    sat_clear = 1'b0;
    check("clr_alone", sat_count, 16'd0);

    // Five beats with a 6-cycle downstream stall; beat k gives every sample = k
    sent = 0;
    rcvd = 0;
    stall_prev = 1'b0;
    held = '0;
    for (int c = 0; c < 40 && rcvd < 5; c++) begin
      m_ready = !(c >= 4 && c < 10);
      s_valid = (sent < 5);
      s_data  = bin(0, 8 * (sent + 1), 0);
      s_last  = (sent == 4);
      #1;
      if (m_valid && !m_ready) begin
        check("stall_ready", s_ready, 1'b0);
        if (stall_prev) check("stall_hold", m_data, held);
        held = m_data;
        stall_prev = 1'b1;
      end else begin
        stall_prev = 1'b0;
      end
      if (m_valid && m_ready) begin
        logic [7:0] v;
        v = 8'(rcvd + 1);
        check("strm_data", m_data, {8{v}});
        check("strm_last", m_last, (rcvd == 4));
        $display("stream beat %0d: data=%h last=%0d", rcvd + 1, m_data, m_last);
        rcvd++;
      end
      if (s_valid && s_ready) sent++;
      step();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    m_ready = 1'b1;
    check("strm_count", rcvd, 5);
    step();
    check("strm_drained", m_valid, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
